vocab_scan_matcher: RTL and testbench
=====================================

Name: vocab_scan_matcher

Overview:
- Parametrised successor to the single-lane vocabulary matcher.
- Holds a vocabulary of fixed-length byte words in an internal register array and accepts search requests over a valid/ready handshake.
- Compares LANES entries per cycle over a caller-given address range, with exact or prefix matching.
- Returns the lowest matching index, or a null-sentinel / range-overflow indication, over a valid/ready response channel. Sits between the tokenizer front-end and the embedding lookup.

Parameters:
- ADDR_WIDTH, 4: vocab depth is 2**ADDR_WIDTH entries.
- WORD_LENGTH, 3: bytes per entry.
- DATA_WIDTH, 8: bits per byte/character.
- LANES, 2: entries compared per cycle; power of two, ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- wr_en  in  1  vocab write strobe. Honoured only in IDLE.
- wr_addr  in  ADDR_WIDTH  vocab write address.
- wr_data  in  WORD_LENGTH*DATA_WIDTH  entry. Byte 0 (first char) in the MSBs; zero-padded.
- req_valid  in  1  search request valid.
- req_ready  out  1  high in IDLE only.
- req_word  in  WORD_LENGTH*DATA_WIDTH  search word, same packing as wr_data.
- req_len  in  $clog2(WORD_LENGTH+1)  significant bytes, 1..WORD_LENGTH.
- req_prefix  in  1  0 = exact match, 1 = prefix match.
- req_start  in  ADDR_WIDTH  first address to scan.
- req_end  in  ADDR_WIDTH  last address to scan, inclusive.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_hit  out  1  match found.
- rsp_nullptr  out  1  scan stopped on an all-zero entry.
- rsp_overflow  out  1  scan passed req_end with no hit and no null entry.
- rsp_index  out  ADDR_WIDTH  address of the hit, the null entry, or req_end.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; all vocab entries are cleared to zero (null).
  - rsp_valid, rsp_hit, rsp_nullptr and rsp_overflow are 0; rsp_index is 0; req_ready is 1 after reset releases.
  - Reset mid-scan aborts the search silently; no response is produced.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_valid && req_ready latches req_word, req_len, req_prefix, req_end, and curr = req_start. Next state is SCAN.
  - wr_en writes the entry on the same edge. A write and an accepted request on the same edge: the write commits first, so the search sees it.
- SCAN: each cycle compares lanes i = 0..LANES-1 at address curr+i.
  - A lane is valid if curr+i ≤ req_end, computed without wrap (ADDR_WIDTH+1-bit sum).
  - Exact match: all WORD_LENGTH bytes equal. Req bytes beyond req_len must be zero; a nonzero padding byte cannot match.
  - Prefix match: the first req_len bytes are equal; the remaining bytes are ignored.
  - Null entry: all bytes zero. A null at a lower valid lane stops the scan before any higher lane is considered.
  - Priority within a group: the lowest valid lane that is a hit or null wins.
  - Hit → rsp_hit=1, rsp_index = lane address. Null → rsp_nullptr=1, rsp_index = lane address. Either moves to RESP.
  - Otherwise, if curr+LANES > req_end (or the sum exceeds 2**ADDR_WIDTH-1) → rsp_overflow=1, rsp_index=req_end, RESP. Else curr += LANES.
  - req_start > req_end: first SCAN cycle has no valid lanes → overflow with rsp_index=req_end.
  - req_start need not be lane-aligned.
- Latency: rsp_valid rises G+1 cycles after the accept edge, where G is the number of groups scanned (minimum 2 cycles).
- RESP:
  - rsp_valid=1. All rsp_* outputs hold stable until rsp_ready.
  - rsp_valid && rsp_ready → IDLE, rsp_valid=0. req_ready rises the cycle after.
  - Exactly one of rsp_hit, rsp_nullptr, rsp_overflow is 1 while rsp_valid=1.
- wr_en outside IDLE is ignored: no write occurs and the vocab is unchanged.

Decomposition:
- Package vocab_pkg holds:
  - function byte_at(word, k) for MSB-first byte extraction;
  - enum state_t {IDLE, SCAN, RESP};
  - response-flag encoding.
- One sub-module, vocab_lane_cmp: combinational compare of one entry against the latched word, req_len and req_prefix. Outputs match and is_null. Instantiated LANES times by generate.

Test Plan (ADDR_WIDTH=4, WORD_LENGTH=3, DATA_WIDTH=8, LANES=2 unless stated):
1. Write "Hel" (48_65_6C) at 5, non-null filler "zzz" at 0–4 and 6–15. Search exact "Hel", len 3, range 0..15 → rsp_hit=1, rsp_index=5, rsp_valid 4 cycles after accept.
2. "abc" at 6 and 7, filler elsewhere, exact search range 0..15 → rsp_index=6. Repeat with LANES=4 → rsp_index=6, rsp_valid 3 cycles after accept.
3. "Hex" at 3, "Hel" at 5. Prefix search "He" (48_65_00), len 2 → rsp_hit=1, rsp_index=3. Same word exact → rsp_hit=0.
4. Entries 0–7 filler, entry 8 left null, "Hel" at 9. Search "Hel" range 0..15 → rsp_nullptr=1, rsp_index=8, rsp_hit=0.
5. All entries filler. Search range 10..15 → rsp_overflow=1, rsp_index=15. Range start 9, end 4 → overflow, rsp_index=4, 2 cycles.
6. Hold rsp_ready=0 for 5 cycles → outputs stable and req_ready=0; wr_en to entry 2 meanwhile is dropped and read back unchanged. Then rst_n low mid-SCAN → rsp_valid=0 and all entries null afterwards.

Source files
------------

// File: rtl/vocab_pkg.sv
// Shared types and helpers for the vocabulary scan matcher.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package vocab_pkg;

    // Upper bounds that let byte_at serve any instance geometry.
    localparam int MAX_WORD_BITS  = 256;
    localparam int MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // Response outcome. Exactly one bit is set for a delivered response.
    typedef struct packed {
        logic hit;
        logic nullptr;
        logic overflow;
    } rsp_flags_t;

    localparam rsp_flags_t FLAGS_NONE     = 3'b000;
    localparam rsp_flags_t FLAGS_HIT      = 3'b100;
    localparam rsp_flags_t FLAGS_NULL     = 3'b010;
    localparam rsp_flags_t FLAGS_OVERFLOW = 3'b001;

    // Byte k of a word_length-byte word, byte 0 in the MSBs.
    // The caller zero-extends the word to MAX_WORD_BITS.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_at(
        input logic [MAX_WORD_BITS-1:0] word,
        input int                       k,
        input int                       word_length,
        input int                       data_width
    );
        logic [MAX_WORD_BITS-1:0]  sh;
        logic [MAX_DATA_WIDTH-1:0] b;
        sh = word >> ((word_length - 1 - k) * data_width);
        b  = sh[MAX_DATA_WIDTH-1:0];
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i >= data_width) b[i] = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/vocab_lane_cmp.sv
// One compare lane: checks a vocab entry against the latched search word.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the result is consumed.
// Ports: entry/word (MSB-first bytes), len (significant bytes), prefix
// (1 = prefix match) -> match, is_null (entry is all zero).
module vocab_lane_cmp
    import vocab_pkg::*;
#(
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = 2
) (
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] entry,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    input  logic [LEN_WIDTH-1:0]              len,
    input  logic                              prefix,
    output logic                              match,
    output logic                              is_null
);

    logic [MAX_WORD_BITS-1:0]  entry_ext;
    logic [MAX_WORD_BITS-1:0]  word_ext;
    logic [MAX_DATA_WIDTH-1:0] eb;
    logic [MAX_DATA_WIDTH-1:0] wb;
    logic                      all_eq;
    logic                      pre_eq;
    logic                      pad_zero;

    assign entry_ext = MAX_WORD_BITS'(entry);
    assign word_ext  = MAX_WORD_BITS'(word);

    always_comb begin
        eb       = '0;
        wb       = '0;
        all_eq   = 1'b1;
        pre_eq   = 1'b1;
        pad_zero = 1'b1;
        for (int k = 0; k < WORD_LENGTH; k++) begin
            eb = byte_at(entry_ext, k, WORD_LENGTH, DATA_WIDTH);
            wb = byte_at(word_ext, k, WORD_LENGTH, DATA_WIDTH);
            if (eb != wb) all_eq = 1'b0;
            if (k < int'(len)) begin
                if (eb != wb) pre_eq = 1'b0;
            end else if (wb != '0) begin
                // Garbage past req_len makes an exact search unmatchable.
                pad_zero = 1'b0;
            end
        end
        match   = prefix ? pre_eq : (all_eq && pad_zero);
        is_null = (entry == '0);
    end

endmodule

// File: rtl/vocab_scan_matcher.sv
// Vocabulary store plus multi-lane range scanner returning the lowest hit.
// Latency: rsp_valid rises G+1 cycles after accept (G = groups scanned).
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
// Ports: wr_* vocab write (IDLE only); req_* search request (valid/ready);
// rsp_* result (valid/ready) with hit / nullptr / overflow and index.
module vocab_scan_matcher
    import vocab_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LANES       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0]    wr_data,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0]    req_word,
    input  logic [$clog2(WORD_LENGTH+1)-1:0]     req_len,
    input  logic                                 req_prefix,
    input  logic [ADDR_WIDTH-1:0]                req_start,
    input  logic [ADDR_WIDTH-1:0]                req_end,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic                                 rsp_hit,
    output logic                                 rsp_nullptr,
    output logic                                 rsp_overflow,
    output logic [ADDR_WIDTH-1:0]                rsp_index
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;
    localparam int LEN_W  = $clog2(WORD_LENGTH + 1);
    localparam int SUM_W  = ADDR_WIDTH + 1;

    state_t                  state;
    state_t                  state_nxt;

    logic [WORD_W-1:0]       vocab [DEPTH];
    logic [WORD_W-1:0]       word_q;
    logic [LEN_W-1:0]        len_q;
    logic                    prefix_q;
    logic [ADDR_WIDTH-1:0]   end_q;
    logic [ADDR_WIDTH-1:0]   curr;

    // The resolved result is registered first and presented the cycle
    // after, so the lane compare path never reaches the response pins.
    logic                    res_pend;
    rsp_flags_t              res_flags;
    logic [ADDR_WIDTH-1:0]   res_index;

    logic [LANES-1:0]        lane_vld;
    logic [LANES-1:0]        lane_match;
    logic [LANES-1:0]        lane_null;
    logic [ADDR_WIDTH-1:0]   lane_addr [LANES];

    logic                    found;
    rsp_flags_t              found_flags;
    logic [ADDR_WIDTH-1:0]   found_index;
    logic [SUM_W-1:0]        next_sum;
    logic                    group_last;

    // Lane addresses use a one-bit-wider sum so a group running past the
    // top of the vocab is masked instead of wrapping back to entry 0.
    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        logic [SUM_W-1:0] lane_sum;

        assign lane_sum     = {1'b0, curr} + SUM_W'(i);
        assign lane_vld[i]  = (lane_sum <= {1'b0, end_q});
        assign lane_addr[i] = lane_sum[ADDR_WIDTH-1:0];

        vocab_lane_cmp #(
            .WORD_LENGTH (WORD_LENGTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .LEN_WIDTH   (LEN_W)
        ) u_cmp (
            .entry   (vocab[lane_addr[i]]),
            .word    (word_q),
            .len     (len_q),
            .prefix  (prefix_q),
            .match   (lane_match[i]),
            .is_null (lane_null[i])
        );
    end

    // Lowest valid lane that is a hit or a null wins. A null entry marks
    // the end of the live vocab, so it outranks a hit on the same lane.
    always_comb begin
        found       = 1'b0;
        found_flags = FLAGS_NONE;
        found_index = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_vld[i] && (lane_null[i] || lane_match[i])) begin
                found       = 1'b1;
                found_index = lane_addr[i];
                found_flags = lane_null[i] ? FLAGS_NULL : FLAGS_HIT;
            end
        end
    end

    assign next_sum   = {1'b0, curr} + SUM_W'(LANES);
    assign group_last = (next_sum > {1'b0, end_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SCAN;
            SCAN:    if (res_pend)  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) vocab[a] <= '0;
            word_q    <= '0;
            len_q     <= '0;
            prefix_q  <= 1'b0;
            end_q     <= '0;
            curr      <= '0;
            res_pend  <= 1'b0;
            res_flags <= FLAGS_NONE;
            res_index <= '0;
        end else begin
            // A write alongside an accepted request lands before the first
            // scan cycle reads the array, so the search sees it.
            if (state == IDLE && wr_en) vocab[wr_addr] <= wr_data;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        word_q   <= req_word;
                        len_q    <= req_len;
                        prefix_q <= req_prefix;
                        end_q    <= req_end;
                        curr     <= req_start;
                        res_pend <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!res_pend) begin
                        if (found) begin
                            res_pend  <= 1'b1;
                            res_flags <= found_flags;
                            res_index <= found_index;
                        end else if (group_last) begin
                            res_pend  <= 1'b1;
                            res_flags <= FLAGS_OVERFLOW;
                            res_index <= end_q;
                        end else begin
                            curr <= next_sum[ADDR_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign rsp_hit      = rsp_valid & res_flags.hit;
    assign rsp_nullptr  = rsp_valid & res_flags.nullptr;
    assign rsp_overflow = rsp_valid & res_flags.overflow;
    assign rsp_index    = rsp_valid ? res_index : '0;

endmodule

// File: tb/tb_vocab_scan_matcher.sv
// Directed bench for vocab_scan_matcher: LANES=2 and LANES=4 instances share stimulus.
// Latency: checked per vector against hand-computed group counts.
// Backpressure: response hold and write-drop exercised in a hand sequence.
module tb_vocab_scan_matcher;

    localparam logic [23:0] HEL = 24'h48656C;
    localparam logic [23:0] HEX = 24'h486578;
    localparam logic [23:0] ABC = 24'h616263;
    localparam logic [23:0] ZZZ = 24'h7A7A7A;
    localparam logic [23:0] QQQ = 24'h717171;
    localparam logic [23:0] XYZ = 24'h78797A;
    localparam logic [23:0] HE  = 24'h486500;
    localparam logic [23:0] Z1  = 24'h7A0000;
    localparam logic [2:0]  FH  = 3'b100;
    localparam logic [2:0]  FN  = 3'b010;
    localparam logic [2:0]  FO  = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        req_valid;
    logic [23:0] req_word;
    logic [1:0]  req_len;
    logic        req_prefix;
    logic [3:0]  req_start;
    logic [3:0]  req_end;
    logic        rsp_ready;

    logic        rdy2, vld2, hit2, nul2, ovf2;
    logic [3:0]  idx2;
    logic        rdy4, vld4, hit4, nul4, ovf4;
    logic [3:0]  idx4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vocab_scan_matcher #(.ADDR_WIDTH(4), .WORD_LENGTH(3), .DATA_WIDTH(8), .LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(rdy2), .req_word(req_word), .req_len(req_len),
        .req_prefix(req_prefix), .req_start(req_start), .req_end(req_end),
        .rsp_valid(vld2), .rsp_ready(rsp_ready), .rsp_hit(hit2), .rsp_nullptr(nul2),
        .rsp_overflow(ovf2), .rsp_index(idx2)
    );

    vocab_scan_matcher #(.ADDR_WIDTH(4), .WORD_LENGTH(3), .DATA_WIDTH(8), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(rdy4), .req_word(req_word), .req_len(req_len),
        .req_prefix(req_prefix), .req_start(req_start), .req_end(req_end),
        .rsp_valid(vld4), .rsp_ready(rsp_ready), .rsp_hit(hit4), .rsp_nullptr(nul4),
        .rsp_overflow(ovf4), .rsp_index(idx4)
    );

    typedef struct {
        string       name;
        logic [23:0] word;
        logic [1:0]  len;
        logic        prefix;
        logic [3:0]  s;
        logic [3:0]  e;
        logic [2:0]  flags;
        logic [3:0]  idx;
        int          lat2;
        int          lat4;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic write_entry(input logic [3:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Presents a request (ready is high in IDLE), waits for the LANES=2
    // response and records both instances' latency and outputs.
    task automatic run_req(input logic [23:0] w, input logic [1:0] l, input logic p,
                           input logic [3:0] s, input logic [3:0] e,
                           output int lat2, output int lat4,
                           output logic [2:0] f2, output logic [3:0] i2,
                           output logic [2:0] f4, output logic [3:0] i4);
        req_valid  = 1'b1;
        req_word   = w;
        req_len    = l;
        req_prefix = p;
        req_start  = s;
        req_end    = e;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'b0;
        lat2 = 0;
        lat4 = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat4 == 0 && vld4) lat4 = c;
            if (vld2) begin
                lat2 = c;
                break;
            end
        end
        f2 = {hit2, nul2, ovf2};
        i2 = idx2;
        f4 = {hit4, nul4, ovf4};
        i4 = idx4;
    endtask

    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_after_ack_vld_rdy"}, 32'({vld2, vld4, rdy2, rdy4}), 32'(4'b0011));
    endtask

    task automatic search_check(input string tag, input logic [23:0] w, input logic [1:0] l,
                                input logic p, input logic [3:0] s, input logic [3:0] e,
                                input logic [2:0] ef, input logic [3:0] ei,
                                input int el2, input int el4);
        int lat2, lat4;
        logic [2:0] f2, f4;
        logic [3:0] i2, i4;
        check({tag, "_req_ready"}, 32'(rdy2), 32'(1));
        run_req(w, l, p, s, e, lat2, lat4, f2, i2, f4, i4);
        check({tag, "_flags_l2"}, 32'(f2), 32'(ef));
        check({tag, "_index_l2"}, 32'(i2), 32'(ei));
        check({tag, "_latency_l2"}, 32'(lat2), 32'(el2));
        check({tag, "_flags_l4"}, 32'(f4), 32'(ef));
        check({tag, "_index_l4"}, 32'(i4), 32'(ei));
        if (el4 > 0) check({tag, "_latency_l4"}, 32'(lat4), 32'(el4));
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat2, lat4;
        logic [2:0] f2, f4;
        logic [3:0] i2, i4;
        int seen;

        // Vocab image: 0-2 zzz, 3 Hex, 4 zzz, 5 Hel, 6-7 abc, 8 null, 9 Hel, 10-15 zzz.
        vecs[0]  = '{"exact_hel",     HEL, 2'd3, 1'b0, 4'd0,  4'd15, FH, 4'd5,  4, 3};
        vecs[1]  = '{"exact_abc",     ABC, 2'd3, 1'b0, 4'd0,  4'd15, FH, 4'd6,  5, 3};
        vecs[2]  = '{"prefix_he",     HE,  2'd2, 1'b1, 4'd0,  4'd15, FH, 4'd3,  3, 2};
        vecs[3]  = '{"exact_he_null", HE,  2'd2, 1'b0, 4'd0,  4'd15, FN, 4'd8,  6, 4};
        vecs[4]  = '{"null_before",   HEL, 2'd3, 1'b0, 4'd7,  4'd15, FN, 4'd8,  2, 2};
        vecs[5]  = '{"ovf_10_15",     HEL, 2'd3, 1'b0, 4'd10, 4'd15, FO, 4'd15, 4, 3};
        vecs[6]  = '{"ovf_rev_9_4",   HEL, 2'd3, 1'b0, 4'd9,  4'd4,  FO, 4'd4,  2, 2};
        vecs[7]  = '{"single_9",      HEL, 2'd3, 1'b0, 4'd9,  4'd9,  FH, 4'd9,  2, 2};
        vecs[8]  = '{"bad_padding",   ZZZ, 2'd1, 1'b0, 4'd0,  4'd2,  FO, 4'd2,  3, 2};
        vecs[9]  = '{"prefix_z",      Z1,  2'd1, 1'b1, 4'd0,  4'd15, FH, 4'd0,  2, 2};
        vecs[10] = '{"single_7",      ABC, 2'd3, 1'b0, 4'd7,  4'd7,  FH, 4'd7,  2, 2};
        vecs[11] = '{"prefix_from_4", HE,  2'd2, 1'b1, 4'd4,  4'd15, FH, 4'd5,  2, 2};
        vecs[12] = '{"top_edge_15",   HEL, 2'd3, 1'b0, 4'd15, 4'd15, FO, 4'd15, 2, 2};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_word = '0; req_len = '0; req_prefix = 1'b0;
        req_start = '0; req_end = '0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({vld2, hit2, nul2, ovf2, idx2}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'({rdy2, rdy4}), 32'(2'b11));

        for (int a = 0; a < 16; a++) write_entry(4'(a), ZZZ);
        write_entry(4'd3, HEX);
        write_entry(4'd5, HEL);
        write_entry(4'd6, ABC);
        write_entry(4'd7, ABC);
        write_entry(4'd8, 24'h0);
        write_entry(4'd9, HEL);

        for (int v = 0; v < 13; v++) begin
            search_check(vecs[v].name, vecs[v].word, vecs[v].len, vecs[v].prefix,
                         vecs[v].s, vecs[v].e, vecs[v].flags, vecs[v].idx,
                         vecs[v].lat2, vecs[v].lat4);
        end

        // Write and request accepted on the same edge: search must see qqq at 12.
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = QQQ;
        search_check("same_edge_write", QQQ, 2'd3, 1'b0, 4'd10, 4'd15, FH, 4'd12, 3, 2);

        // Hold the response for 5 cycles; a write attempted meanwhile is dropped.
        run_req(HEL, 2'd3, 1'b0, 4'd0, 4'd15, lat2, lat4, f2, i2, f4, i4);
        check("hold_initial", 32'({f2, i2}), 32'({FH, 4'd5}));
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = HEL;
            end
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0;
            check($sformatf("hold_c%0d", c),
                  32'({vld2, rdy2, hit2, nul2, ovf2, idx2}), 32'({1'b1, 1'b0, FH, 4'd5}));
        end
        drain("hold");
        search_check("dropped_write", HEL, 2'd3, 1'b0, 4'd2, 4'd2, FO, 4'd2, 2, 2);

        // Reset in the middle of a scan: no response, vocab wiped.
        req_valid = 1'b1; req_word = XYZ; req_len = 2'd3; req_prefix = 1'b0;
        req_start = 4'd10; req_end = 4'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midscan_reset_state", 32'({vld2, vld4, rdy2, rdy4}), 32'(4'b0011));
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (vld2 || vld4) seen++;
        end
        check("midscan_no_response", 32'(seen), 32'(0));
        search_check("wiped_0", HEL, 2'd3, 1'b0, 4'd0, 4'd15, FN, 4'd0, 2, 2);
        search_check("wiped_5", HEL, 2'd3, 1'b0, 4'd5, 4'd5, FN, 4'd5, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
